// File: rtl/tlb_pkg.sv
// Shared definitions for the CP0-side TLB operation controller:
// op codes, CP0 register numbers, FSM states and EntryHi/EntryLo field layout.
package tlb_pkg;

  typedef enum logic [1:0] {
    OP_TLBP  = 2'd0,
    OP_TLBR  = 2'd1,
    OP_TLBWI = 2'd2,
    OP_TLBWR = 2'd3
  } tlb_op_e;

  localparam logic [4:0] CP0_INDEX    = 5'd0;
  localparam logic [4:0] CP0_RANDOM   = 5'd1;
  localparam logic [4:0] CP0_ENTRYLO0 = 5'd2;
  localparam logic [4:0] CP0_ENTRYLO1 = 5'd3;
  localparam logic [4:0] CP0_WIRED    = 5'd6;
  localparam logic [4:0] CP0_ENTRYHI  = 5'd10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PROBE = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } tlb_state_e;

  localparam int INDEX_P_BIT  = 31;
  localparam int EHI_VPN2_MSB = 31;
  localparam int EHI_VPN2_LSB = 13;
  localparam int EHI_ASID_MSB = 7;
  localparam int ELO_PFN_MSB  = 25;
  localparam int ELO_PFN_LSB  = 6;
  localparam int ELO_C_LSB    = 3;
  localparam int ELO_D_BIT    = 2;
  localparam int ELO_V_BIT    = 1;
  localparam int ELO_G_BIT    = 0;

  // Member order matches the architectural bit order, so the struct maps onto bits 25..0.
  typedef struct packed {
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
    logic        g;
  } entrylo_t;

  function automatic entrylo_t elo_from_word(input logic [31:0] w);
    entrylo_t e;
    e.pfn = w[ELO_PFN_MSB:ELO_PFN_LSB];
    e.c   = w[ELO_PFN_LSB-1:ELO_C_LSB];
    e.d   = w[ELO_D_BIT];
    e.v   = w[ELO_V_BIT];
    e.g   = w[ELO_G_BIT];
    return e;
  endfunction

endpackage

// File: rtl/tlb_op_ctrl_if.sv
// Bundle of the request handshake, CP0 access port and TLB search/read/write
// ports; slave is the controller, master is the pipeline plus TLB side.
interface tlb_op_ctrl_if #(
  parameter int IDX_W = 4
) ();

  logic             req_valid;
  logic [1:0]       req_op;
  logic             req_ready;
  logic             done;
  logic             flush;

  logic             cp0_we;
  logic [4:0]       cp0_addr;
  logic [31:0]      cp0_wdata;
  logic [4:0]       cp0_raddr;
  logic [31:0]      cp0_rdata;

  logic             tlbp;
  logic [18:0]      s_vpn2;
  logic [7:0]       s_asid;
  logic             s_found;
  logic [IDX_W-1:0] s_index;

  logic             wr;
  logic [IDX_W-1:0] w_index;
  logic [18:0]      w_vpn2;
  logic [7:0]       w_asid;
  logic             w_g;
  logic [19:0]      w_pfn0;
  logic [2:0]       w_c0;
  logic             w_d0;
  logic             w_v0;
  logic [19:0]      w_pfn1;
  logic [2:0]       w_c1;
  logic             w_d1;
  logic             w_v1;

  logic [IDX_W-1:0] r_index;
  logic [18:0]      r_vpn2;
  logic [7:0]       r_asid;
  logic             r_g;
  logic [19:0]      r_pfn0;
  logic [2:0]       r_c0;
  logic             r_d0;
  logic             r_v0;
  logic [19:0]      r_pfn1;
  logic [2:0]       r_c1;
  logic             r_d1;
  logic             r_v1;

  modport slave (
    input  req_valid, req_op, cp0_we, cp0_addr, cp0_wdata, cp0_raddr,
           s_found, s_index,
           r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1,
    output req_ready, done, flush, cp0_rdata, tlbp, s_vpn2, s_asid,
           wr, w_index, w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0,
           w_pfn1, w_c1, w_d1, w_v1, r_index
  );

  modport master (
    output req_valid, req_op, cp0_we, cp0_addr, cp0_wdata, cp0_raddr,
           s_found, s_index,
           r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1,
    input  req_ready, done, flush, cp0_rdata, tlbp, s_vpn2, s_asid,
           wr, w_index, w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0,
           w_pfn1, w_c1, w_d1, w_v1, r_index
  );

endinterface

// File: rtl/tlb_random_cnt.sv
// CP0 Random register: free-running down-counter that wraps from Wired (or 0)
// back to the top entry, restarts on a Wired write and parks when Wired is out of range.
module tlb_random_cnt #(
  parameter int TLB_NUM = 16,
  parameter int IDX_W   = $clog2(TLB_NUM)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [IDX_W:0]   wired,
  input  logic             wired_we,
  output logic [IDX_W-1:0] random
);

  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(TLB_NUM - 1);
  localparam logic [IDX_W:0]   NUM_W   = (IDX_W + 1)'(TLB_NUM);

  logic [IDX_W-1:0] random_r;
  logic [IDX_W-1:0] random_nxt_s;

  // Next Random value
  always_comb begin
    random_nxt_s = random_r;
    if (wired_we) begin
      random_nxt_s = TOP_IDX;
    end else if (wired >= NUM_W) begin
      random_nxt_s = TOP_IDX;
    end else if (({1'b0, random_r} == wired) || (random_r == '0)) begin
      random_nxt_s = TOP_IDX;
    end else begin
      random_nxt_s = random_r - IDX_W'(1);
    end
  end

  // Random register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      random_r <= TOP_IDX;
    end else begin
      random_r <= random_nxt_s;
    end
  end

  assign random = random_r;

endmodule

// File: rtl/tlb_op_ctrl.sv
// CP0-side TLB controller: owns Index/Random/Wired/EntryHi/EntryLo0/EntryLo1 and
// sequences TLBP/TLBR/TLBWI/TLBWR against the TLB search, read and write ports.
module tlb_op_ctrl
  import tlb_pkg::*;
#(
  parameter int TLB_NUM = 16,
  parameter int IDX_W   = $clog2(TLB_NUM)
) (
  input  logic          clk,
  input  logic          resetn,
  tlb_op_ctrl_if.slave  bus
);

  tlb_state_e       state_r, next_state_s;
  tlb_op_e          op_r;
  logic             accept_s;

  logic             idx_p_r;
  logic [IDX_W-1:0] idx_r;
  logic [IDX_W:0]   wired_r;
  logic [IDX_W-1:0] random_s;
  logic [18:0]      ehi_vpn2_r;
  logic [7:0]       ehi_asid_r;
  entrylo_t         lo0_r, lo1_r;

  logic             tlbp_r, wr_r, done_r, flush_r, ready_r;
  logic             we_index_s, we_wired_s, we_ehi_s, we_lo0_s, we_lo1_s;
  logic [31:0]      rdata_s;

  assign accept_s   = (state_r == ST_IDLE) && bus.req_valid;
  assign we_index_s = bus.cp0_we && (bus.cp0_addr == CP0_INDEX);
  assign we_wired_s = bus.cp0_we && (bus.cp0_addr == CP0_WIRED);
  assign we_ehi_s   = bus.cp0_we && (bus.cp0_addr == CP0_ENTRYHI);
  assign we_lo0_s   = bus.cp0_we && (bus.cp0_addr == CP0_ENTRYLO0);
  assign we_lo1_s   = bus.cp0_we && (bus.cp0_addr == CP0_ENTRYLO1);

  // FSM state register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.req_valid) begin
          case (tlb_op_e'(bus.req_op))
            OP_TLBP:           next_state_s = ST_PROBE;
            OP_TLBR:           next_state_s = ST_READ;
            OP_TLBWI, OP_TLBWR: next_state_s = ST_WRITE;
            default:           next_state_s = ST_IDLE;
          endcase
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_PROBE, ST_READ, ST_WRITE: next_state_s = ST_DONE;
      ST_DONE:                     next_state_s = ST_IDLE;
      default:                     next_state_s = ST_IDLE;
    endcase
  end

  // Strobes are registered from the next state so each lines up with its state cycle
  always_ff @(posedge clk) begin
    if (!resetn) begin
      op_r    <= OP_TLBP;
      tlbp_r  <= 1'b0;
      wr_r    <= 1'b0;
      done_r  <= 1'b0;
      flush_r <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      if (accept_s) begin
        op_r <= tlb_op_e'(bus.req_op);
      end
      tlbp_r  <= (next_state_s == ST_PROBE);
      wr_r    <= (next_state_s == ST_WRITE);
      done_r  <= (next_state_s == ST_DONE);
      flush_r <= (next_state_s == ST_DONE) && (op_r != OP_TLBP);
      ready_r <= (next_state_s == ST_IDLE);
    end
  end

  // Index: probe result has priority over a same-cycle MTC0
  always_ff @(posedge clk) begin
    if (!resetn) begin
      idx_p_r <= 1'b0;
      idx_r   <= '0;
    end else if (state_r == ST_PROBE) begin
      idx_p_r <= ~bus.s_found;
      idx_r   <= bus.s_found ? bus.s_index : '0;
    end else if (we_index_s) begin
      idx_p_r <= 1'b0;
      idx_r   <= bus.cp0_wdata[IDX_W-1:0];
    end
  end

  // EntryHi/EntryLo: TLB read data has priority over a same-cycle MTC0
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ehi_vpn2_r <= '0;
      ehi_asid_r <= '0;
      lo0_r      <= '0;
      lo1_r      <= '0;
    end else if (state_r == ST_READ) begin
      ehi_vpn2_r <= bus.r_vpn2;
      ehi_asid_r <= bus.r_asid;
      lo0_r      <= {bus.r_pfn0, bus.r_c0, bus.r_d0, bus.r_v0, bus.r_g};
      lo1_r      <= {bus.r_pfn1, bus.r_c1, bus.r_d1, bus.r_v1, bus.r_g};
    end else begin
      if (we_ehi_s) begin
        ehi_vpn2_r <= bus.cp0_wdata[EHI_VPN2_MSB:EHI_VPN2_LSB];
        ehi_asid_r <= bus.cp0_wdata[EHI_ASID_MSB:0];
      end
      if (we_lo0_s) begin
        lo0_r <= elo_from_word(bus.cp0_wdata);
      end
      if (we_lo1_s) begin
        lo1_r <= elo_from_word(bus.cp0_wdata);
      end
    end
  end

  // Wired register; one extra bit so out-of-range values are visible to the counter
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wired_r <= '0;
    end else if (we_wired_s) begin
      wired_r <= bus.cp0_wdata[IDX_W:0];
    end
  end

  tlb_random_cnt #(
    .TLB_NUM (TLB_NUM),
    .IDX_W   (IDX_W)
  ) u_random (
    .clk      (clk),
    .resetn   (resetn),
    .wired    (wired_r),
    .wired_we (we_wired_s),
    .random   (random_s)
  );

  // MFC0 read mux
  always_comb begin
    rdata_s = 32'd0;
    case (bus.cp0_raddr)
      CP0_INDEX: begin
        rdata_s[INDEX_P_BIT] = idx_p_r;
        rdata_s[IDX_W-1:0]   = idx_r;
      end
      CP0_RANDOM:   rdata_s[IDX_W-1:0]   = random_s;
      CP0_WIRED:    rdata_s[IDX_W:0]     = wired_r;
      CP0_ENTRYLO0: rdata_s[ELO_PFN_MSB:0] = lo0_r;
      CP0_ENTRYLO1: rdata_s[ELO_PFN_MSB:0] = lo1_r;
      CP0_ENTRYHI: begin
        rdata_s[EHI_VPN2_MSB:EHI_VPN2_LSB] = ehi_vpn2_r;
        rdata_s[EHI_ASID_MSB:0]            = ehi_asid_r;
      end
      default: rdata_s = 32'd0;
    endcase
  end

  assign bus.cp0_rdata = rdata_s;
  assign bus.req_ready = ready_r;
  assign bus.done      = done_r;
  assign bus.flush     = flush_r;
  assign bus.tlbp      = tlbp_r;
  assign bus.s_vpn2    = ehi_vpn2_r;
  assign bus.s_asid    = ehi_asid_r;
  assign bus.r_index   = idx_r;

  assign bus.wr        = wr_r;
  assign bus.w_index   = (op_r == OP_TLBWR) ? random_s : idx_r;
  assign bus.w_vpn2    = ehi_vpn2_r;
  assign bus.w_asid    = ehi_asid_r;
  assign bus.w_g       = lo0_r.g & lo1_r.g;
  assign bus.w_pfn0    = lo0_r.pfn;
  assign bus.w_c0      = lo0_r.c;
  assign bus.w_d0      = lo0_r.d;
  assign bus.w_v0      = lo0_r.v;
  assign bus.w_pfn1    = lo1_r.pfn;
  assign bus.w_c1      = lo1_r.c;
  assign bus.w_d1      = lo1_r.d;
  assign bus.w_v1      = lo1_r.v;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed bench for tlb_op_ctrl with a small TLB model behind the search/write ports.
module tb_tlb_op_ctrl;
  import tlb_pkg::*;

  localparam int TLB_NUM = 16;
  localparam int IDX_W   = 4;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  tlb_op_ctrl_if #(.IDX_W(IDX_W)) bus ();

  tlb_op_ctrl #(.TLB_NUM(TLB_NUM), .IDX_W(IDX_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;

  // TLB model: entries filled by the controller's write port, searched by EntryHi
  logic        m_valid [TLB_NUM];
  logic [18:0] m_vpn2  [TLB_NUM];
  logic [7:0]  m_asid  [TLB_NUM];
  logic        m_g     [TLB_NUM];

  always @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < TLB_NUM; i++) m_valid[i] <= 1'b0;
    end else if (bus.wr) begin
      m_valid[bus.w_index] <= 1'b1;
      m_vpn2[bus.w_index]  <= bus.w_vpn2;
      m_asid[bus.w_index]  <= bus.w_asid;
      m_g[bus.w_index]     <= bus.w_g;
    end
  end

  always_comb begin
    bus.s_found = 1'b0;
    bus.s_index = '0;
    for (int i = TLB_NUM - 1; i >= 0; i--) begin
      if (m_valid[i] && (m_vpn2[i] == bus.s_vpn2) && (m_g[i] || (m_asid[i] == bus.s_asid))) begin
        bus.s_found = 1'b1;
        bus.s_index = IDX_W'(i);
      end
    end
  end

  // Reference Random/Wired behaviour
  logic [3:0] rand_m;
  logic [4:0] wired_m;
  always @(posedge clk) begin
    if (!resetn) begin
      rand_m  <= 4'd15;
      wired_m <= 5'd0;
    end else begin
      if (bus.cp0_we && bus.cp0_addr == 5'd6) wired_m <= bus.cp0_wdata[4:0];
      if (bus.cp0_we && bus.cp0_addr == 5'd6) rand_m <= 4'd15;
      else if (wired_m >= 5'd16) rand_m <= 4'd15;
      else if ({1'b0, rand_m} == wired_m || rand_m == 4'd0) rand_m <= 4'd15;
      else rand_m <= rand_m - 4'd1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.cp0_we    = 1'b1;
    bus.cp0_addr  = a;
    bus.cp0_wdata = d;
    tick();
    bus.cp0_we    = 1'b0;
  endtask

  task automatic mfc0(input logic [4:0] a, output logic [31:0] d);
    bus.cp0_raddr = a;
    #1;
    d = bus.cp0_rdata;
  endtask

  // Values observed during the last operation
  int          op_done_at, op_wr_cnt, op_tlbp_cnt, op_both, op_busy_ready, op_ready_back;
  logic        op_flush;
  logic [3:0]  cap_w_index, cap_rand;
  logic [18:0] cap_vpn2;
  logic [7:0]  cap_asid;
  logic [19:0] cap_pfn0, cap_pfn1;
  logic        cap_g, cap_v0, cap_d0;

  task automatic run_op(input string tag, input tlb_op_e op, input logic inj,
                        input logic [4:0] ia, input logic [31:0] id);
    op_done_at = -1; op_flush = 1'b0; op_wr_cnt = 0; op_tlbp_cnt = 0;
    op_both = 0; op_busy_ready = 0; op_ready_back = 0;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) begin
        bus.req_valid = 1'b0;
        if (inj) begin
          bus.cp0_we = 1'b1; bus.cp0_addr = ia; bus.cp0_wdata = id;
        end
      end else begin
        bus.cp0_we = 1'b0;
      end
      if (bus.wr) begin
        op_wr_cnt++;
        cap_w_index = bus.w_index; cap_rand = rand_m;
        cap_vpn2 = bus.w_vpn2; cap_asid = bus.w_asid; cap_g = bus.w_g;
        cap_pfn0 = bus.w_pfn0; cap_pfn1 = bus.w_pfn1; cap_v0 = bus.w_v0; cap_d0 = bus.w_d0;
      end
      if (bus.tlbp) op_tlbp_cnt++;
      if (bus.wr && bus.tlbp) op_both++;
      if (k <= 2 && bus.req_ready) op_busy_ready++;
      if (k == 3 && bus.req_ready) op_ready_back = 1;
      if (bus.done && op_done_at < 0) begin
        op_done_at = k;
        op_flush   = bus.flush;
      end
    end
    check({tag, ".done_latency"}, op_done_at, 2);
    check({tag, ".flush"}, op_flush, (op != OP_TLBP));
    check({tag, ".wr_cycles"}, op_wr_cnt, (op == OP_TLBWI || op == OP_TLBWR) ? 1 : 0);
    check({tag, ".tlbp_cycles"}, op_tlbp_cnt, (op == OP_TLBP) ? 1 : 0);
    check({tag, ".wr_and_tlbp"}, op_both, 0);
    check({tag, ".ready_busy"}, op_busy_ready, 0);
    check({tag, ".ready_back"}, op_ready_back, 1);
  endtask

  logic [31:0] d;

  initial begin
    resetn = 1'b0;
    bus.req_valid = 1'b0; bus.req_op = 2'd0;
    bus.cp0_we = 1'b0; bus.cp0_addr = 5'd0; bus.cp0_wdata = 32'd0; bus.cp0_raddr = 5'd0;
    bus.r_vpn2 = 19'd0; bus.r_asid = 8'd0; bus.r_g = 1'b0;
    bus.r_pfn0 = 20'd0; bus.r_c0 = 3'd0; bus.r_d0 = 1'b0; bus.r_v0 = 1'b0;
    bus.r_pfn1 = 20'd0; bus.r_c1 = 3'd0; bus.r_d1 = 1'b0; bus.r_v1 = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst.tlbp", bus.tlbp, 0);
    check("rst.wr", bus.wr, 0);
    check("rst.done", bus.done, 0);
    check("rst.flush", bus.flush, 0);
    check("rst.ready", bus.req_ready, 1);
    mfc0(5'd0, d);  check("rst.index", d, 32'h0);
    mfc0(5'd6, d);  check("rst.wired", d, 32'h0);
    mfc0(5'd10, d); check("rst.entryhi", d, 32'h0);
    mfc0(5'd2, d);  check("rst.entrylo0", d, 32'h0);
    mfc0(5'd3, d);  check("rst.entrylo1", d, 32'h0);
    mfc0(5'd7, d);  check("rst.unimpl", d, 32'h0);

    // Random walks 15..0 then wraps with Wired=0
    resetn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      mfc0(5'd1, d);
      check("random_seq", d, 32'(15 - (i % 16)));
      tick();
    end

    // Register formats: unused bits read 0, Index P cleared, Random read-only
    mtc0(5'd10, 32'hFFFF_FFFF); mfc0(5'd10, d); check("fmt.entryhi", d, 32'hFFFF_E0FF);
    mtc0(5'd2, 32'hFFFF_FFFF);  mfc0(5'd2, d);  check("fmt.entrylo0", d, 32'h03FF_FFFF);
    mtc0(5'd0, 32'hFFFF_FFFF);  mfc0(5'd0, d);  check("fmt.index", d, 32'h0000_000F);
    mtc0(5'd1, 32'h0000_0003);  mfc0(5'd1, d);  check("fmt.random_ro", d, {28'd0, rand_m});

    // TLBWI of a global entry at index 3
    mtc0(5'd10, 32'h0000_2005);
    mtc0(5'd2, 32'h0000_0047);
    mtc0(5'd3, 32'h0000_0087);
    mtc0(5'd0, 32'h0000_0003);
    run_op("tlbwi1", OP_TLBWI, 1'b0, 5'd0, 32'd0);
    check("tlbwi1.w_index", cap_w_index, 3);
    check("tlbwi1.w_vpn2", cap_vpn2, 1);
    check("tlbwi1.w_asid", cap_asid, 5);
    check("tlbwi1.w_pfn0", cap_pfn0, 1);
    check("tlbwi1.w_pfn1", cap_pfn1, 2);
    check("tlbwi1.w_g", cap_g, 1);
    check("tlbwi1.w_v0_d0", {cap_v0, cap_d0}, 2'b11);

    // TLBP hit; an MTC0 to Index in the PROBE cycle loses to the probe result
    mtc0(5'd0, 32'h0000_0000);
    run_op("tlbp_hit", OP_TLBP, 1'b1, 5'd0, 32'h0000_0007);
    mfc0(5'd0, d); check("tlbp_hit.index", d, 32'h0000_0003);

    // Rewrite entry 3 as non-global, then probe with a different ASID
    mtc0(5'd2, 32'h0000_0046);
    mtc0(5'd3, 32'h0000_0086);
    mtc0(5'd0, 32'h0000_0003);
    run_op("tlbwi2", OP_TLBWI, 1'b0, 5'd0, 32'd0);
    check("tlbwi2.w_g", cap_g, 0);
    mtc0(5'd10, 32'h0000_2006);
    run_op("tlbp_miss", OP_TLBP, 1'b0, 5'd0, 32'd0);
    mfc0(5'd0, d); check("tlbp_miss.index", d, 32'h8000_0000);

    // TLBR from index 3
    mtc0(5'd0, 32'h0000_0003);
    bus.r_vpn2 = 19'h7; bus.r_asid = 8'h9; bus.r_g = 1'b0;
    bus.r_pfn0 = 20'h10; bus.r_c0 = 3'd3; bus.r_d0 = 1'b1; bus.r_v0 = 1'b1;
    bus.r_pfn1 = 20'h20; bus.r_c1 = 3'd5; bus.r_d1 = 1'b0; bus.r_v1 = 1'b1;
    #1; check("tlbr.r_index", bus.r_index, 3);
    run_op("tlbr", OP_TLBR, 1'b0, 5'd0, 32'd0);
    mfc0(5'd10, d); check("tlbr.entryhi", d, 32'h0000_E009);
    mfc0(5'd2, d);  check("tlbr.entrylo0", d, 32'h0000_041E);
    mfc0(5'd3, d);  check("tlbr.entrylo1", d, 32'h0000_082A);

    // Wired=4: Random restarts at 15 and cycles 15..4
    mtc0(5'd6, 32'h0000_0004);
    mfc0(5'd1, d); check("wired4.restart", d, 32'd15);
    mfc0(5'd6, d); check("wired4.readback", d, 32'd4);
    for (int i = 0; i < 12; i++) begin
      tick();
      mfc0(5'd1, d);
      check("wired4.random_seq", d, (i < 11) ? 32'(14 - i) : 32'd15);
    end
    for (int n = 0; n < 6; n++) begin
      repeat (n * 3) tick();
      run_op("tlbwr", OP_TLBWR, 1'b0, 5'd0, 32'd0);
      check("tlbwr.w_index_random", cap_w_index, cap_rand);
      check("tlbwr.w_index_ge_wired", (cap_w_index >= 4'd4), 1);
    end

    // Wired beyond the TLB size parks Random at 15
    mtc0(5'd6, 32'h0000_0014);
    for (int i = 0; i < 3; i++) begin
      mfc0(5'd1, d); check("wired_big.random", d, 32'd15);
      tick();
    end
    mtc0(5'd6, 32'h0000_0000);

    // Reset during PROBE abandons the operation
    bus.req_valid = 1'b1; bus.req_op = OP_TLBP;
    tick();
    check("abort.tlbp_seen", bus.tlbp, 1);
    bus.req_valid = 1'b0;
    resetn = 1'b0;
    tick();
    check("abort.done", bus.done, 0);
    check("abort.flush", bus.flush, 0);
    check("abort.wr", bus.wr, 0);
    check("abort.tlbp", bus.tlbp, 0);
    check("abort.ready", bus.req_ready, 1);
    mfc0(5'd0, d); check("abort.index", d, 32'h0);
    mfc0(5'd1, d); check("abort.random", d, 32'd15);
    resetn = 1'b1;
    tick();
    check("abort.done_after", bus.done, 0);
    check("abort.flush_after", bus.flush, 0);
    check("abort.ready_after", bus.req_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tlb_op_ctrl.md
Name: tlb_op_ctrl

Overview:
- CP0-side controller that drives the dual-search TLB's probe, read and write ports on behalf of TLBP, TLBR, TLBWI and TLBWR, which are issued from the WB stage.
- Owns the architectural Index, Random, Wired, EntryHi, EntryLo0 and EntryLo1 registers, and services MTC0/MFC0 accesses to them.
- Sequences each TLB instruction through a small FSM and signals completion plus a pipeline refetch.

Parameters:
- TLB_NUM, 16, number of TLB entries.
- IDX_W, $clog2(TLB_NUM), index width.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous reset, active low.
- req_valid  in  1  TLB instruction request.
- req_op  in  2  0=TLBP, 1=TLBR, 2=TLBWI, 3=TLBWR.
- req_ready  out  1  high only in IDLE.
- done  out  1  one-cycle completion pulse.
- flush  out  1  refetch pulse, coincident with done for TLBR/TLBWI/TLBWR.
- cp0_we  in  1  MTC0 write strobe.
- cp0_addr  in  5  CP0 register number: 0 Index, 1 Random, 2 EntryLo0, 3 EntryLo1, 6 Wired, 10 EntryHi.
- cp0_wdata  in  32  MTC0 data.
- cp0_raddr  in  5  MFC0 register number.
- cp0_rdata  out  32  combinational read data; unimplemented numbers read 0.
- tlbp  out  1  drives the TLB s1_tlbp input.
- s_vpn2  out  19  EntryHi.VPN2, driven to TLB s1_vpn2.
- s_asid  out  8  EntryHi.ASID, driven to TLB s1_asid.
- s_found  in  1  TLB s1_found.
- s_index  in  IDX_W  TLB s1_index.
- wr  out  1  TLB write enable.
- w_index  out  IDX_W  write index.
- w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1  out  19/8/1/20/3/1/1/20/3/1/1  TLB write fields.
- r_index  out  IDX_W  TLB read index; always equals Index.index.
- r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1  in  (same widths)  TLB read data.

Behaviour:
- Register formats:
  - Index: P[31], index[IDX_W-1:0].
  - EntryHi: VPN2[31:13], ASID[7:0].
  - EntryLo: PFN[25:6], C[5:3], D[2], V[1], G[0].
  - Unused bits read 0.
- Reset values: Index=0, Wired=0, Random=TLB_NUM-1, EntryHi=0, EntryLo0/1=0. Outputs: tlbp=0, wr=0, done=0, flush=0, req_ready=1.
- FSM states: IDLE, PROBE, READ, WRITE, DONE.
  - IDLE: req_valid accepted when req_ready. TLBP->PROBE, TLBR->READ, TLBWI/TLBWR->WRITE.
  - PROBE (1 cycle): tlbp=1. Capture Index: s_found ? {P=0, index=s_index} : {P=1, index=0}.
  - READ (1 cycle): capture EntryHi={r_vpn2, r_asid}, EntryLo0={r_pfn0, r_c0, r_d0, r_v0, r_g}, EntryLo1 likewise with r_g.
  - WRITE (1 cycle): wr=1. w_index = Index.index for TLBWI, Random for TLBWR (value sampled in the WRITE cycle). w_g = EntryLo0.G & EntryLo1.G. Other w_* fields come from EntryHi/EntryLo.
  - DONE (1 cycle): done=1; flush=1 unless the op was TLBP. Returns to IDLE.
- Latency: accept to done is 2 cycles; the next request can be accepted the cycle after DONE.
- wr and tlbp are never asserted outside their states, and never both high in the same cycle.
- Random:
  - Decrements every cycle.
  - When Random==Wired (or Random==0), the next value is TLB_NUM-1.
  - An MTC0 to Wired forces Random=TLB_NUM-1 the next cycle.
  - If Wired>=TLB_NUM, Random holds at TLB_NUM-1.
  - Random is read-only; MTC0 to register 1 is ignored.
- MTC0:
  - Takes effect the next cycle in any state.
  - On a same-cycle conflict for the same register, the FSM capture (PROBE/READ) wins. Other registers update normally.
  - Index writes keep only the index bits; P is cleared.
- MFC0 is combinational from the current register state.
- resetn low mid-operation: the FSM returns to IDLE and no done/flush/wr is emitted in the following cycle.
- req_valid while not ready is ignored; the requester holds the request.

Decomposition:
- Shared package tlb_pkg:
  - op encodings TLBP/TLBR/TLBWI/TLBWR.
  - CP0 register numbers.
  - FSM state enum.
  - EntryLo/EntryHi field bit positions.
- One sub-module, tlb_random_cnt: Random counter taking Wired and a Wired-write strobe.

Test Plan:
- Reset, then 20 idle cycles -> Random sequence 15,14,…,0,15,… with Wired=0. All outputs at reset values.
- MTC0 EntryHi=0x0000_2005, Lo0=0x0000_0047, Lo1=0x0000_0087, Index=3; then TLBWI -> one wr cycle with w_index=3, w_vpn2=1, w_asid=5, w_pfn0=1, w_pfn1=2, w_g=1. done and flush arrive 2 cycles after accept.
- After the above, TLBP with matching EntryHi -> Index reads 0x0000_0003. Change ASID to 6 with G=0 entry, then TLBP -> Index=0x8000_0000, flush=0.
- TLBR with Index=3, TLB model returning vpn2=0x7, asid=9, pfn0=0x10 -> EntryHi=0x0000_E009, EntryLo0 PFN field=0x10, done+flush pulse.
- MTC0 Wired=4, then TLBWR over many cycles -> w_index always in 4..15; Random restarts at 15 the cycle after the Wired write.
- TLBP issued, then resetn low in the PROBE cycle -> no done, Index stays 0, req_ready=1 after reset.
